itrx_aib_phy_clk_div_mux: RTL and testbench
===========================================

// Module: itrx_aib_phy_clk_div_mux
// PURPOSE
//  Parametrised, glitch-free N-way clock divider/selector for the AIB PHY.
//  - Generates a registered divided clock from clk.
//  - The divide ratio is chosen from NUM_CH configured half-periods.
//  - Ratio switches are handshaked and applied only on a phase boundary.
//  - Therefore no output phase is ever shorter than min(old,new) half-period.
//  - Feeds PHY-internal slow clocks (DLL/calibration, sideband) from the PHY reference clock.
// PARAMETERS
//  NUM_CH   4     number of selectable divide channels (>=2)
//  CNT_W    8     width of each half-period config field and of the counter
//  RST_SEL  0     channel active out of reset (< NUM_CH)
//  SEL_W    $clog2(NUM_CH)  localparam, channel select width
// PORTS
//  clk          in   1              source clock; all logic on its rising edge
//  rst          in   1              asynchronous, active-high reset
//  div_cfg      in   NUM_CH*CNT_W   half-period per channel, ch i at [i*CNT_W +: CNT_W]; quasi-static
//  en           in   1              divider run enable
//  sel          in   SEL_W          requested channel, sampled when sel_req=1
//  sel_req      in   1              switch request, 1-cycle pulse
//  sel_ack      out  1              1-cycle pulse: requested channel now active
//  busy         out  1              a switch request is pending
//  active_sel   out  SEL_W          channel currently driving the divider
//  clk_div_out  out  1              divided clock, registered (flop output, no comb path)
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - clk_div_out=0, cnt=0, active_sel=RST_SEL, pending=0, sel_ack=0, busy=0.
//  Half-period
//   - H = div_cfg field of active_sel; H=0 is treated as 1.
//   - Output period is 2*H clk cycles at 50% duty (H=1 gives clk/2).
//  Counter
//   - cnt increments while running.
//   - When cnt==H-1, clk_div_out toggles next edge and cnt clears.
//  States
//   - IDLE: en=0 and output low; cnt held at 0.
//   - RUN: output toggling.
//   - STOP: en fell during a high phase; finish the high phase, then go to IDLE.
//  Transitions
//   - IDLE->RUN when en=1: full low phase of H cycles first, then high.
//   - RUN: en=0 in a low phase -> IDLE at once (output already low, cnt cleared).
//   - RUN: en=0 in a high phase -> STOP.
//   - STOP->IDLE at the falling toggle.
//   - en=1 during STOP is ignored until IDLE is reached.
//  Switch request
//   - sel_req=1 loads pending_sel<=sel, pending<=1, and busy=1 from the next cycle.
//   - Another sel_req while pending overwrites pending_sel; only one ack is issued.
//  Switch commit
//   - Happens on the edge where the output would toggle 0->1 (end of a low phase).
//   - That edge sets active_sel<=pending_sel, cnt<=0, pending<=0, sel_ack<=1.
//   - The high phase that follows uses the new H.
//  Switch in IDLE
//   - In IDLE (incl. en=0) a pending switch commits on the next cycle.
//  Same-channel request
//   - sel==active_sel still goes through the handshake (ack at the next boundary).
//  Simultaneous events
//   - sel_req on the commit edge: the commit uses the older pending_sel and acks it.
//   - The new request stays pending (busy stays 1).
//  div_cfg changes
//   - A change to the active field takes effect at the next cnt clear.
//   - If the new H-1 < cnt, the phase ends at the counter wrap.
//   - The phase is never cut short below its programmed length.
//  Reset mid-phase
//   - Output drops to 0 asynchronously.
//   - This is the only permitted short phase.
//  Latency
//   - en rise to first clk_div_out rise: H+1 cycles.
//   - Switch latency is at most 2*H_old+1 cycles after sel_req.
// TESTING
//  1 NUM_CH=4, cfg={8,4,2,1}, RST_SEL=0, en=1 -> period 2 cycles, output high 1 / low 1; active_sel=0.
//  2 Running ch0 (H=1), sel_req sel=2 (H=4) -> one sel_ack pulse at a 0->1 edge; then 4 high / 4 low; no phase <1.
//  3 Running ch2 (H=4), sel_req sel=0 then sel=3 two cycles later -> single ack, active_sel=3 (H=8), busy 1->0.
//  4 en=0 two cycles into a 4-cycle high phase -> high holds 2 more cycles, then low.
//    Re-enable -> 4 low cycles, then high.
//  5 div_cfg field=0 selected -> behaves as H=1; rst pulse mid-high -> output 0 at once, active_sel=RST_SEL.
//  6 Random sel_req/en/cfg for 10k cycles; checker: every phase >= min(H_old,H_new), one ack per commit, ack only on 0->1.

Source files
------------

// File: rtl/itrx_aib_phy_clk_div_mux_if.sv
// Control/status bundle for the AIB PHY clock divider/selector.
// The master drives configuration and switch requests; the slave reports the divided clock and switch status.
interface itrx_aib_phy_clk_div_mux_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [NUM_CH*CNT_W-1:0] div_cfg;
  logic                    en;
  logic [SEL_W-1:0]        sel;
  logic                    sel_req;
  logic                    sel_ack;
  logic                    busy;
  logic [SEL_W-1:0]        active_sel;
  logic                    clk_div_out;

  modport master (
    output div_cfg, en, sel, sel_req,
    input  sel_ack, busy, active_sel, clk_div_out
  );

  modport slave (
    input  div_cfg, en, sel, sel_req,
    output sel_ack, busy, active_sel, clk_div_out
  );
endinterface

// File: rtl/itrx_aib_phy_clk_div_mux.sv
// Glitch-free N-way clock divider/selector. A ratio switch is committed only at the end of a low phase,
// so the high phase that follows it already runs at the new half-period.
module itrx_aib_phy_clk_div_mux #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int RST_SEL = 0
) (
  input logic                    clk,
  input logic                    rst,
  itrx_aib_phy_clk_div_mux_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_out;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_active;
  logic             r_pend;
  logic [SEL_W-1:0] r_pend_sel;
  logic             r_ack;

  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_hm1;
  logic             w_term;
  logic             w_out_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_commit;

  // Half-period of the active channel; a zero field behaves like H=1.
  always_comb begin
    w_h = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (r_active == SEL_W'(i)) w_h = bus.div_cfg[i*CNT_W +: CNT_W];
  end

  assign w_hm1 = (w_h == '0) ? '0 : w_h - CNT_W'(1);
  // Strict equality: if the field shrinks below cnt, the counter runs on through its wrap,
  // so a phase is never shortened.
  assign w_term = (r_cnt == w_hm1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.en) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!bus.en) begin
          if (!r_out || w_term) w_state_nxt = S_IDLE;
          else                  w_state_nxt = S_STOP;
        end
      end
      S_STOP: if (w_term) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath logic
  always_comb begin
    w_out_nxt = r_out;
    w_cnt_nxt = r_cnt;
    w_commit  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_out_nxt = 1'b0;
        w_cnt_nxt = '0;
        w_commit  = r_pend;
      end
      S_RUN: begin
        if (!bus.en && !r_out) begin
          w_cnt_nxt = '0;
        end else if (w_term) begin
          w_out_nxt = ~r_out;
          w_cnt_nxt = '0;
          w_commit  = r_pend && !r_out;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (w_term) begin
          w_out_nxt = 1'b0;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_out_nxt = 1'b0;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // A request landing on the commit edge stays pending; the commit takes the older selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out      <= 1'b0;
      r_cnt      <= '0;
      r_active   <= SEL_W'(RST_SEL);
      r_pend     <= 1'b0;
      r_pend_sel <= SEL_W'(RST_SEL);
      r_ack      <= 1'b0;
    end else begin
      r_out  <= w_out_nxt;
      r_cnt  <= w_cnt_nxt;
      r_ack  <= w_commit;
      r_pend <= bus.sel_req | (r_pend & ~w_commit);
      if (w_commit)    r_active   <= r_pend_sel;
      if (bus.sel_req) r_pend_sel <= bus.sel;
    end
  end

  assign bus.clk_div_out = r_out;
  assign bus.sel_ack     = r_ack;
  assign bus.busy        = r_pend;
  assign bus.active_sel  = r_active;
endmodule

// File: tb/tb_itrx_aib_phy_clk_div_mux.sv
// Directed bench for the clock divider/selector: waveform shapes, switch handshake, stop/restart,
// zero half-period, async reset and a request colliding with a commit.
module tb_itrx_aib_phy_clk_div_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  itrx_aib_phy_clk_div_mux_if #(.NUM_CH(4), .CNT_W(8)) bus_if ();

  itrx_aib_phy_clk_div_mux #(.NUM_CH(4), .CNT_W(8), .RST_SEL(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag, input int budget, input int exp_n);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus_if.sel_ack && n < budget);
    chk(tag, n, exp_n);
  endtask

  initial begin
    logic [31:0] pat;
    int acks;

    bus_if.div_cfg = 32'h08_04_02_01;
    bus_if.en      = 1'b0;
    bus_if.sel     = '0;
    bus_if.sel_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_out",    bus_if.clk_div_out, 0);
    chk("rst_active", bus_if.active_sel,  0);
    chk("rst_busy",   bus_if.busy,        0);
    chk("rst_ack",    bus_if.sel_ack,     0);

    // ch0, H=1: clk/2 after one idle-to-run cycle
    bus_if.en = 1'b1;
    pat = 0;
    for (int i = 0; i < 6; i++) begin tick(); pat[i] = bus_if.clk_div_out; end
    chk("t1_wave",   pat, 32'b101010);
    chk("t1_active", bus_if.active_sel, 0);

    // switch ch0 -> ch2 (H=4)
    bus_if.sel = 2'd2; bus_if.sel_req = 1'b1;
    tick();
    chk("t2_busy", bus_if.busy, 1);
    chk("t2_ack0", bus_if.sel_ack, 0);
    chk("t2_out0", bus_if.clk_div_out, 0);
    bus_if.sel_req = 1'b0;
    tick();
    chk("t2_ack",    bus_if.sel_ack, 1);
    chk("t2_active", bus_if.active_sel, 2);
    chk("t2_busy0",  bus_if.busy, 0);
    chk("t2_rise",   bus_if.clk_div_out, 1);
    pat = 0; acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick(); pat[i] = bus_if.clk_div_out; acks += int'(bus_if.sel_ack);
    end
    chk("t2_wave", pat, 32'b1000_0111);
    chk("t2_acks", acks, 0);

    // two requests, the second overwrites: single ack, ch3 (H=8)
    bus_if.sel = 2'd0; bus_if.sel_req = 1'b1;
    tick();
    bus_if.sel_req = 1'b0;
    tick();
    bus_if.sel = 2'd3; bus_if.sel_req = 1'b1;
    tick();
    bus_if.sel_req = 1'b0;
    chk("t3_busy", bus_if.busy, 1);
    pat = 0;
    for (int i = 0; i < 5; i++) begin tick(); pat[i] = bus_if.sel_ack; end
    chk("t3_ackpos", pat, 32'b10000);
    chk("t3_active", bus_if.active_sel, 3);
    chk("t3_busy0",  bus_if.busy, 0);
    chk("t3_rise",   bus_if.clk_div_out, 1);
    pat = 0; acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); pat[i] = bus_if.clk_div_out; acks += int'(bus_if.sel_ack);
    end
    chk("t3_wave", pat, 32'h07F);
    chk("t3_acks", acks, 0);

    // back to ch2, then drop en two cycles into the high phase
    bus_if.sel = 2'd2; bus_if.sel_req = 1'b1;
    tick();
    bus_if.sel_req = 1'b0;
    wait_ack("t4_sw_lat", 20, 5);
    chk("t4_active", bus_if.active_sel, 2);
    tick();
    chk("t4_high", bus_if.clk_div_out, 1);
    bus_if.en = 1'b0;
    pat = 0;
    for (int i = 0; i < 4; i++) begin tick(); pat[i] = bus_if.clk_div_out; end
    chk("t4_stop", pat, 32'b0011);
    bus_if.en = 1'b1;
    pat = 0;
    for (int i = 0; i < 5; i++) begin tick(); pat[i] = bus_if.clk_div_out; end
    chk("t4_restart", pat, 32'b10000);

    // ch1 field programmed to 0 behaves as H=1
    bus_if.div_cfg = 32'h08_04_00_01;
    bus_if.sel = 2'd1; bus_if.sel_req = 1'b1;
    tick();
    bus_if.sel_req = 1'b0;
    wait_ack("t5_sw_lat", 20, 7);
    chk("t5_active", bus_if.active_sel, 1);
    pat = 0;
    for (int i = 0; i < 4; i++) begin tick(); pat[i] = bus_if.clk_div_out; end
    chk("t5_wave", pat, 32'b1010);

    // async reset while high
    rst = 1'b1;
    #2;
    chk("t5_rst_out",    bus_if.clk_div_out, 0);
    chk("t5_rst_active", bus_if.active_sel, 0);
    chk("t5_rst_busy",   bus_if.busy, 0);

    // request arriving on the commit edge while idle
    bus_if.en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    bus_if.sel = 2'd3; bus_if.sel_req = 1'b1;
    tick();
    chk("t6_busy",   bus_if.busy, 1);
    chk("t6_act0",   bus_if.active_sel, 0);
    chk("t6_ack0",   bus_if.sel_ack, 0);
    bus_if.sel = 2'd2;
    tick();
    chk("t6_act3",   bus_if.active_sel, 3);
    chk("t6_ack1",   bus_if.sel_ack, 1);
    chk("t6_busy1",  bus_if.busy, 1);
    bus_if.sel_req = 1'b0;
    tick();
    chk("t6_act2",   bus_if.active_sel, 2);
    chk("t6_ack2",   bus_if.sel_ack, 1);
    chk("t6_busy2",  bus_if.busy, 0);
    tick();
    chk("t6_ackend", bus_if.sel_ack, 0);
    chk("t6_idle",   bus_if.clk_div_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
